// File: rtl/ps2_host.sv
// Host-side PS/2 link controller: conditions the device clock and data, receives
// device frames, and sends command bytes using the inhibit / request-to-send sequence.
module ps2_host #(
    parameter int INHIBIT_CYCLES = 10_000,
    parameter int RTS_CYCLES     = 200,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic       clk,
    input  logic       reset,
    inout  wire        ps2_clk,
    inout  wire        ps2_data,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_err,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_err,
    output logic       busy
);
    localparam int FW = $clog2(FILTER_LEN + 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_RX, ST_TX_INHIBIT, ST_TX_RTS, ST_TX_BITS, ST_TX_ACK
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    clk_s_q, data_s_q;
    logic          filt_q, filt_d;
    logic [FW-1:0] flt_cnt_q, flt_cnt_d;
    logic [31:0]   tmr_q, tmr_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [8:0]    rx_sh_q, rx_sh_d;
    logic [8:0]    tx_sh_q, tx_sh_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          clk_oe_q, clk_oe_d, data_oe_q, data_oe_d;
    logic          tx_done_q, tx_done_d, tx_err_q, tx_err_d;
    logic          rx_valid_q, rx_valid_d, rx_err_q, rx_err_d;
    logic          busy_q;
    logic          fall, data_smp, timeout;

    // Pins only ever pull low; the pull-up on the bus supplies the high level.
    assign ps2_clk  = clk_oe_q  ? 1'b0 : 1'bz;
    assign ps2_data = data_oe_q ? 1'b0 : 1'bz;

    // NOTE: every always_comb variable gets a default first, so no path infers a latch.
    always_comb begin
        filt_d    = filt_q;
        flt_cnt_d = '0;
        if (clk_s_q[1] != filt_q) begin
            if (flt_cnt_q == FW'(FILTER_LEN - 1)) filt_d = clk_s_q[1];
            else                                  flt_cnt_d = flt_cnt_q + FW'(1);
        end
    end

    assign fall     = filt_q & ~filt_d;
    assign data_smp = data_s_q[1];
    assign timeout  = (tmr_q == 32'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d    = state_q;
        tmr_d      = tmr_q + 32'd1;
        bit_cnt_d  = bit_cnt_q;
        rx_sh_d    = rx_sh_q;
        tx_sh_d    = tx_sh_q;
        rx_data_d  = rx_data_q;
        clk_oe_d   = clk_oe_q;
        data_oe_d  = data_oe_q;
        tx_done_d  = 1'b0;
        tx_err_d   = 1'b0;
        rx_valid_d = 1'b0;
        rx_err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tmr_d     = '0;
                bit_cnt_d = '0;
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                if (tx_valid) begin
                    state_d  = ST_TX_INHIBIT;
                    tx_sh_d  = {~^tx_data, tx_data};
                    clk_oe_d = 1'b1;
                end else if (fall) begin
                    if (!data_smp) state_d  = ST_RX;
                    else           rx_err_d = 1'b1;
                end
            end
            ST_RX: begin
                if (fall) begin
                    tmr_d = '0;
                    if (bit_cnt_q == 4'd9) begin
                        state_d = ST_IDLE;
                        if (data_smp && (^rx_sh_q)) begin
                            rx_data_d  = rx_sh_q[7:0];
                            rx_valid_d = 1'b1;
                        end else begin
                            rx_err_d = 1'b1;
                        end
                    end else begin
                        rx_sh_d[bit_cnt_q] = data_smp;
                        bit_cnt_d          = bit_cnt_q + 4'd1;
                    end
                end else if (timeout) begin
                    rx_err_d = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            ST_TX_INHIBIT: begin
                // Our own clock pull-down also yields a filtered fall; the timer ignores it here.
                if (tmr_q == 32'(INHIBIT_CYCLES - 1)) begin
                    data_oe_d = 1'b1;
                    state_d   = ST_TX_RTS;
                end
            end
            ST_TX_RTS: begin
                if (tmr_q == 32'(RTS_CYCLES - 1)) begin
                    clk_oe_d  = 1'b0;
                    bit_cnt_d = '0;
                    state_d   = ST_TX_BITS;
                end
            end
            ST_TX_BITS: begin
                if (fall) begin
                    tmr_d = '0;
                    if (bit_cnt_q == 4'd9) begin
                        data_oe_d = 1'b0;
                        state_d   = ST_TX_ACK;
                    end else begin
                        data_oe_d = ~tx_sh_q[bit_cnt_q];
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end else if (timeout) begin
                    tx_err_d  = 1'b1;
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            ST_TX_ACK: begin
                if (fall) begin
                    tx_done_d = ~data_smp;
                    tx_err_d  = data_smp;
                    state_d   = ST_IDLE;
                end else if (timeout) begin
                    tx_err_d  = 1'b1;
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (state_d != state_q) tmr_d = '0;
    end

    // NOTE: sequential state uses non-blocking assignments only; reset also releases both pins at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            clk_s_q    <= 2'b11;
            data_s_q   <= 2'b11;
            filt_q     <= 1'b1;
            flt_cnt_q  <= '0;
            tmr_q      <= '0;
            bit_cnt_q  <= '0;
            rx_sh_q    <= '0;
            tx_sh_q    <= '0;
            rx_data_q  <= '0;
            clk_oe_q   <= 1'b0;
            data_oe_q  <= 1'b0;
            tx_done_q  <= 1'b0;
            tx_err_q   <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_err_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            clk_s_q    <= {clk_s_q[0], ps2_clk};
            data_s_q   <= {data_s_q[0], ps2_data};
            filt_q     <= filt_d;
            flt_cnt_q  <= flt_cnt_d;
            tmr_q      <= tmr_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_sh_q    <= rx_sh_d;
            tx_sh_q    <= tx_sh_d;
            rx_data_q  <= rx_data_d;
            clk_oe_q   <= clk_oe_d;
            data_oe_q  <= data_oe_d;
            tx_done_q  <= tx_done_d;
            tx_err_q   <= tx_err_d;
            rx_valid_q <= rx_valid_d;
            rx_err_q   <= rx_err_d;
            // Held one extra cycle so busy drops only after the completion strobe.
            busy_q     <= (state_d != ST_IDLE) || (state_q != ST_IDLE);
        end
    end

    assign tx_ready = (state_q == ST_IDLE);
    assign tx_done  = tx_done_q;
    assign tx_err   = tx_err_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign rx_err   = rx_err_q;
    assign busy     = busy_q;
endmodule

// File: tb/tb_ps2_host.sv
// Directed bench for ps2_host: a behavioural mouse drives and answers the open-drain
// PS/2 lines, and each scenario task checks strobes, data and pin levels.
`timescale 1ns/1ps
module tb_ps2_host;
    localparam int INH = 100;
    localparam int RTS = 20;
    localparam int FLT = 8;
    localparam int TO  = 2000;
    localparam int HP  = 300;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx_done, tx_err, rx_valid, rx_err, busy;
    logic [7:0] rx_data;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    wire        ps2_clk_w, ps2_data_w;

    int tests = 0;
    int fails = 0;
    int n_rx_valid = 0, n_rx_err = 0, n_tx_done = 0, n_tx_err = 0, n_overlap = 0;

    pullup (ps2_clk_w);
    pullup (ps2_data_w);
    assign ps2_clk_w  = dev_clk_low  ? 1'b0 : 1'bz;
    assign ps2_data_w = dev_data_low ? 1'b0 : 1'bz;

    ps2_host #(
        .INHIBIT_CYCLES(INH), .RTS_CYCLES(RTS), .FILTER_LEN(FLT), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk_w), .ps2_data(ps2_data_w),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_done(tx_done), .tx_err(tx_err), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_err(rx_err), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid === 1'b1) n_rx_valid++;
        if (rx_err   === 1'b1) n_rx_err++;
        if (tx_done  === 1'b1) n_tx_done++;
        if (tx_err   === 1'b1) n_tx_err++;
        if (int'(rx_valid) + int'(rx_err) + int'(tx_done) + int'(tx_err) > 1) n_overlap++;
    end

    initial begin
        #800_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic par, input logic stop);
        return {stop, par, d, 1'b0};
    endfunction

    // Device-to-host frame: data changes while clk is high, host samples on the fall.
    task automatic dev_frame(input logic [10:0] bits, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            dev_data_low = ~bits[i];
            #(HP) dev_clk_low = 1'b1;
            #(HP) dev_clk_low = 1'b0;
        end
        dev_data_low = 1'b0;
    endtask

    // Host-to-device: device clocks 11 falls, reads data while clk is high, ACKs before fall 11.
    task automatic dev_take_cmd(input logic ack, output logic [8:0] seen, output logic stop_seen);
        seen = '0;
        stop_seen = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            dev_clk_low = 1'b1;
            #(HP) dev_clk_low = 1'b0;
            #(HP/2);
            if (k <= 9) seen[k-1] = ps2_data_w;
            else if (k == 10) begin
                stop_seen    = ps2_data_w;
                dev_data_low = ack;
            end
            #(HP/2);
        end
        dev_data_low = 1'b0;
    endtask

    task automatic send_cmd(input logic [7:0] b);
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        @(posedge clk);
        #1 tx_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        tests++; if (tx_ready !== 1'b1)   begin fails++; $display("FAIL reset_tx_ready got=%b exp=1", tx_ready); end
        tests++; if (busy !== 1'b0)       begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
        tests++; if (rx_data !== 8'h00)   begin fails++; $display("FAIL reset_rx_data got=%h exp=00", rx_data); end
        tests++; if (ps2_clk_w !== 1'b1)  begin fails++; $display("FAIL reset_clk_pin got=%b exp=1", ps2_clk_w); end
        tests++; if (ps2_data_w !== 1'b1) begin fails++; $display("FAIL reset_data_pin got=%b exp=1", ps2_data_w); end
        tests++; if (n_rx_valid + n_rx_err + n_tx_done + n_tx_err !== 0)
            begin fails++; $display("FAIL reset_strobes got=%0d exp=0", n_rx_valid + n_rx_err + n_tx_done + n_tx_err); end
    endtask

    task automatic test_rx_frames;
        int v0, e0;
        v0 = n_rx_valid; e0 = n_rx_err;
        dev_frame(mk_frame(8'h4B, 1'b1, 1'b1), 11);
        repeat (40) @(negedge clk);
        tests++; if (n_rx_valid - v0 !== 1) begin fails++; $display("FAIL rx_good_valid got=%0d exp=1", n_rx_valid - v0); end
        tests++; if (n_rx_err - e0 !== 0)   begin fails++; $display("FAIL rx_good_err got=%0d exp=0", n_rx_err - e0); end
        tests++; if (rx_data !== 8'h4B)     begin fails++; $display("FAIL rx_good_data got=%h exp=4b", rx_data); end
        tests++; if (busy !== 1'b0)         begin fails++; $display("FAIL rx_good_busy got=%b exp=0", busy); end

        v0 = n_rx_valid; e0 = n_rx_err;
        dev_frame(mk_frame(8'h4B, 1'b0, 1'b1), 11);
        repeat (40) @(negedge clk);
        tests++; if (n_rx_err - e0 !== 1)   begin fails++; $display("FAIL rx_parity_err got=%0d exp=1", n_rx_err - e0); end
        tests++; if (n_rx_valid - v0 !== 0) begin fails++; $display("FAIL rx_parity_valid got=%0d exp=0", n_rx_valid - v0); end

        v0 = n_rx_valid; e0 = n_rx_err;
        dev_frame(mk_frame(8'hA6, 1'b1, 1'b0), 11);
        repeat (40) @(negedge clk);
        tests++; if (n_rx_err - e0 !== 1)   begin fails++; $display("FAIL rx_stop_err got=%0d exp=1", n_rx_err - e0); end
        tests++; if (rx_data !== 8'h4B)     begin fails++; $display("FAIL rx_bad_hold got=%h exp=4b", rx_data); end

        v0 = n_rx_valid; e0 = n_rx_err;
        dev_frame(11'h7FF, 1);
        repeat (40) @(negedge clk);
        tests++; if (n_rx_err - e0 !== 1)   begin fails++; $display("FAIL rx_bad_start got=%0d exp=1", n_rx_err - e0); end
        tests++; if (busy !== 1'b0)         begin fails++; $display("FAIL rx_bad_start_busy got=%b exp=0", busy); end

        v0 = n_rx_valid;
        dev_frame(mk_frame(8'h00, 1'b1, 1'b1), 11);
        repeat (40) @(negedge clk);
        tests++; if (n_rx_valid - v0 !== 1 || rx_data !== 8'h00)
            begin fails++; $display("FAIL rx_zero got=%h/%0d exp=00/1", rx_data, n_rx_valid - v0); end
    endtask

    task automatic run_tx(input logic [7:0] b, input logic ack, input logic [8:0] exp_bits, input string tag);
        int n, d0, e0;
        logic [8:0] seen;
        logic stop_seen, start_seen;
        d0 = n_tx_done; e0 = n_tx_err;
        send_cmd(b);
        tests++; if (ps2_clk_w !== 1'b0 || busy !== 1'b1 || tx_ready !== 1'b0)
            begin fails++; $display("FAIL %s_inhibit_start clk=%b busy=%b ready=%b exp=0/1/0", tag, ps2_clk_w, busy, tx_ready); end
        n = 0;
        while (ps2_data_w !== 1'b0 && n < 5000) begin @(posedge clk); #1 n++; end
        tests++; if (n < INH - 1 || n > INH + 1)
            begin fails++; $display("FAIL %s_inhibit_len got=%0d exp=%0d", tag, n, INH); end
        tests++; if (ps2_clk_w !== 1'b0) begin fails++; $display("FAIL %s_clk_held got=%b exp=0", tag, ps2_clk_w); end
        n = 0;
        while (ps2_clk_w !== 1'b1 && n < 5000) begin @(posedge clk); #1 n++; end
        tests++; if (n < RTS - 1 || n > RTS + 1)
            begin fails++; $display("FAIL %s_rts_len got=%0d exp=%0d", tag, n, RTS); end
        #(HP);
        start_seen = ps2_data_w;
        dev_take_cmd(ack, seen, stop_seen);
        repeat (20) @(negedge clk);
        tests++; if (start_seen !== 1'b0) begin fails++; $display("FAIL %s_start got=%b exp=0", tag, start_seen); end
        tests++; if (seen !== exp_bits)   begin fails++; $display("FAIL %s_bits got=%h exp=%h", tag, seen, exp_bits); end
        tests++; if (stop_seen !== 1'b1)  begin fails++; $display("FAIL %s_stop got=%b exp=1", tag, stop_seen); end
        tests++; if (n_tx_done - d0 !== (ack ? 1 : 0))
            begin fails++; $display("FAIL %s_done got=%0d exp=%0d", tag, n_tx_done - d0, ack ? 1 : 0); end
        tests++; if (n_tx_err - e0 !== (ack ? 0 : 1))
            begin fails++; $display("FAIL %s_err got=%0d exp=%0d", tag, n_tx_err - e0, ack ? 0 : 1); end
        tests++; if (ps2_clk_w !== 1'b1 || ps2_data_w !== 1'b1 || busy !== 1'b0 || tx_ready !== 1'b1)
            begin fails++; $display("FAIL %s_after clk=%b data=%b busy=%b ready=%b exp=1/1/0/1", tag, ps2_clk_w, ps2_data_w, busy, tx_ready); end
    endtask

    task automatic test_tx;
        run_tx(8'hF4, 1'b1, 9'h0F4, "tx_f4_ack");
        run_tx(8'hFF, 1'b0, 9'h1FF, "tx_ff_nack");
    endtask

    task automatic test_rx_timeout;
        int v0, e0;
        e0 = n_rx_err; v0 = n_rx_valid;
        dev_frame(mk_frame(8'h4B, 1'b1, 1'b1), 5);
        repeat (TO - 200) @(negedge clk);
        tests++; if (n_rx_err - e0 !== 0 || busy !== 1'b1)
            begin fails++; $display("FAIL to_early err=%0d busy=%b exp=0/1", n_rx_err - e0, busy); end
        repeat (300) @(negedge clk);
        tests++; if (n_rx_err - e0 !== 1 || busy !== 1'b0)
            begin fails++; $display("FAIL to_fire err=%0d busy=%b exp=1/0", n_rx_err - e0, busy); end
        tests++; if (n_rx_valid - v0 !== 0) begin fails++; $display("FAIL to_valid got=%0d exp=0", n_rx_valid - v0); end
        dev_frame(mk_frame(8'h4B, 1'b1, 1'b1), 11);
        repeat (40) @(negedge clk);
        tests++; if (n_rx_valid - v0 !== 1 || rx_data !== 8'h4B || n_rx_err - e0 !== 1)
            begin fails++; $display("FAIL to_recover data=%h valid=%0d err=%0d exp=4b/1/1", rx_data, n_rx_valid - v0, n_rx_err - e0); end
    endtask

    task automatic test_reset_mid_tx;
        int n, s0;
        send_cmd(8'h00);
        n = 0;
        while ((ps2_clk_w !== 1'b1 || ps2_data_w !== 1'b0) && n < 5000) begin @(posedge clk); #1 n++; end
        tests++; if (n >= 5000) begin fails++; $display("FAIL rst_wait_release got=%0d exp<5000", n); end
        #(HP);
        for (int k = 0; k < 3; k++) begin
            dev_clk_low = 1'b1;
            #(HP) dev_clk_low = 1'b0;
            #(HP/2);
        end
        tests++; if (ps2_data_w !== 1'b0 || busy !== 1'b1)
            begin fails++; $display("FAIL rst_pre data=%b busy=%b exp=0/1", ps2_data_w, busy); end
        s0 = n_rx_valid + n_rx_err + n_tx_done + n_tx_err;
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        tests++; if (ps2_clk_w !== 1'b1 || ps2_data_w !== 1'b1)
            begin fails++; $display("FAIL rst_pins clk=%b data=%b exp=1/1", ps2_clk_w, ps2_data_w); end
        tests++; if (busy !== 1'b0 || tx_ready !== 1'b1)
            begin fails++; $display("FAIL rst_busy busy=%b ready=%b exp=0/1", busy, tx_ready); end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int g = 0; g < 6; g++) begin
            #37 dev_clk_low = 1'b1;
            #1  dev_clk_low = 1'b0;
        end
        for (int g = 0; g < 3; g++) begin
            @(negedge clk) dev_clk_low = 1'b1;
            repeat (FLT - 3) @(negedge clk);
            dev_clk_low = 1'b0;
            repeat (20) @(negedge clk);
        end
        tests++; if (n_rx_valid + n_rx_err + n_tx_done + n_tx_err !== s0)
            begin fails++; $display("FAIL glitch_strobes got=%0d exp=%0d", n_rx_valid + n_rx_err + n_tx_done + n_tx_err, s0); end
        tests++; if (busy !== 1'b0 || tx_ready !== 1'b1)
            begin fails++; $display("FAIL glitch_state busy=%b ready=%b exp=0/1", busy, tx_ready); end
    endtask

    initial begin
        test_reset;
        test_rx_frames;
        test_tx;
        test_rx_timeout;
        test_reset_mid_tx;
        tests++; if (n_overlap !== 0) begin fails++; $display("FAIL strobe_overlap got=%0d exp=0", n_overlap); end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
